// File: rtl/ascii_to_int_signed_100_if.sv
// ascii_to_int_signed_100_if: character stream in, valid/ready signed result out
interface ascii_to_int_signed_100_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        out_err;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_value, out_err);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_value, out_err);
endinterface

// File: rtl/ascii_to_int_signed_100.sv
// ascii_to_int_signed_100: byte-serial ASCII decimal parser, [+-]ddd<term> -> signed 32-bit result
// Define ASCII_TO_INT_SAT_EN to saturate well-formed out-of-range magnitudes to +-MAX_MAG.
module ascii_to_int_signed_100 #(
  parameter int MAX_MAG    = 100,
  parameter int MAX_DIGITS = 3
) (
  input logic clock,
  input logic reset_n,
  ascii_to_int_signed_100_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, NUM = 2'd1, HOLD = 2'd2;
  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam logic [9:0] MAX_M = 10'(MAX_MAG);
  localparam logic [NW-1:0] MAX_D = NW'(MAX_DIGITS);
  logic [1:0] state, state_n;
  logic [9:0] mag, mag_n, res_mag;
  logic [NW-1:0] ndig, ndig_n;
  logic neg, neg_n, err, err_n, beat, is_dig, is_term, res_err, fire, take;
  logic [7:0] c;
  logic [31:0] res_val;
  assign c       = bus.in_data;
  assign beat    = bus.in_valid & bus.in_ready;
  assign is_dig  = (c >= 8'h30) && (c <= 8'h39);
  assign is_term = (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
  assign fire    = beat && (state == NUM) && is_term;
  assign take    = bus.out_valid & bus.out_ready;
`ifdef ASCII_TO_INT_SAT_EN
  assign res_err = err | (ndig == '0);
  assign res_mag = (mag > MAX_M) ? MAX_M : mag;
`else
  assign res_err = err | (ndig == '0) | (mag > MAX_M);
  assign res_mag = mag;
`endif
  assign res_val = res_err ? '0 : neg ? -{22'd0, res_mag} : {22'd0, res_mag};
  always_comb begin
    state_n = state;
    mag_n   = mag;
    ndig_n  = ndig;
    neg_n   = neg;
    err_n   = err;
    if (state == HOLD) begin
      if (take) begin
        state_n = IDLE;
        mag_n   = '0;
        ndig_n  = '0;
        neg_n   = 1'b0;
        err_n   = 1'b0;
      end
    end else if (beat && state == IDLE) begin
      if (is_dig) begin
        mag_n   = 10'(c[3:0]);
        ndig_n  = NW'(1);
        state_n = NUM;
      end else if (c == 8'h2B) begin
        state_n = NUM;
      end else if (c == 8'h2D) begin
        neg_n   = 1'b1;
        state_n = NUM;
      end else if (!(c == 8'h20 || is_term)) begin
        err_n   = 1'b1;
        state_n = NUM;
      end
    end else if (beat) begin
      // an over-long digit run flags the error but leaves mag frozen
      if (is_term) state_n = HOLD;
      else if (is_dig && ndig < MAX_D) begin
        mag_n  = mag * 10'd10 + 10'(c[3:0]);
        ndig_n = ndig + NW'(1);
      end else err_n = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mag           <= '0;
      ndig          <= '0;
      neg           <= 1'b0;
      err           <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_value <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      state        <= state_n;
      mag          <= mag_n;
      ndig         <= ndig_n;
      neg          <= neg_n;
      err          <= err_n;
      bus.in_ready <= (state_n != HOLD);
      if (fire) begin
        bus.out_valid <= 1'b1;
        bus.out_value <= res_val;
        bus.out_err   <= res_err;
      end else if (take) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/ascii_to_int_signed_100.md
Name: ascii_to_int_signed_100

Overview:
- Byte-serial ASCII decimal parser; the inverse of the signed-integer-to-ASCII display formatter.
- Consumes one character per accepted beat from a byte source (UART RX path or keypad buffer).
- Assembles an optional sign plus 1-3 digits, closed by a terminator.
- Presents a signed 32-bit value in range -100..+100 to the processor-side consumer over a valid/ready handshake, with an error flag for malformed or out-of-range input.

Parameters:
- MAX_MAG, 100, largest accepted magnitude.
- MAX_DIGITS, 3, maximum digit characters per number.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a character.
- in_data  in  8  ASCII character.
- in_ready  out  1  parser can accept a character this cycle.
- out_valid  out  1  result pending.
- out_ready  in  1  consumer takes the result.
- out_value  out  32  signed two's-complement result.
- out_err  out  1  result is an error frame (out_value = 0).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=0 during reset and 1 in the first cycle after release.
  - out_valid=0, out_value=0, out_err=0.
  - Internals cleared: mag=0, ndig=0, neg=0, err=0.
- Character beat = in_valid & in_ready. Exactly one character is consumed per beat.
- Input FSM:
  - IDLE:
    - ' ' (0x20): ignored.
    - '+': neg=0, go to NUM.
    - '-': neg=1, go to NUM.
    - '0'-'9': mag=digit, ndig=1, go to NUM.
    - Terminator (CR 0x0D, LF 0x0A, ',' 0x2C): ignored, so blank lines produce no result.
    - Any other character: err=1, go to NUM.
  - NUM:
    - Digit with ndig<MAX_DIGITS: mag=mag*10+digit, ndig++.
    - Digit with ndig==MAX_DIGITS: err=1; mag is left unchanged.
    - Terminator: go to HOLD.
    - Any other character, including a second sign or a space: err=1; keep consuming until a terminator.
  - HOLD:
    - in_ready=0.
    - Result registered on entry, in the same cycle as the terminator beat:
      - If err, or ndig==0, or mag>MAX_MAG: out_err=1, out_value=0.
      - Otherwise out_err=0, out_value=neg ? -mag : mag, sign-extended to 32 bits.
    - out_valid=1 from the cycle after the terminator beat.
    - Holds while out_ready=0; out_value and out_err stay stable while out_valid=1.
    - out_valid&out_ready: out_valid=0, internals cleared, go to IDLE.
    - in_ready=1 in the next cycle.
- Latency: terminator beat to out_valid = 1 cycle. Minimum turnaround from accepted result to the next accepted character = 1 cycle.
- in_ready = (state != HOLD), registered off state. It does not depend combinationally on in_valid or out_ready.
- Arithmetic:
  - mag is 10 bits unsigned (max 999).
  - "-0" yields 0 with out_err=0.
  - Leading zeros count toward MAX_DIGITS: "007" is valid, "0007" is an error.
- in_data is ignored whenever in_valid=0.
- Reset mid-number discards any partial state. Reset while out_valid=1 drops the pending result.

Optional Feature:
- Macro: ASCII_TO_INT_SAT_EN.
- Defined: a well-formed number with mag>MAX_MAG saturates to ±MAX_MAG with out_err=0. Syntax errors (bad character, excess digits, no digits) still produce out_err=1.
- Undefined: mag>MAX_MAG produces out_err=1, out_value=0, as specified above.

Test Plan:
- "-42\r" with out_ready=1 -> out_valid pulses 1 cycle after '\r' beat, out_value=0xFFFFFFD6, out_err=0, in_ready returns 1 next cycle.
- "  +100\n" then "100," back-to-back -> two results, +100 then +100, out_err=0; leading spaces consumed with no output.
- "101\n" -> out_err=1, out_value=0; with ASCII_TO_INT_SAT_EN defined -> out_value=100, out_err=0. Also "-250\n" -> err, or -100 when saturating.
- Malformed inputs:
  - "1a2\n" -> out_err=1.
  - "0007\n" -> out_err=1.
  - "-\n" -> out_err=1.
  - "\r\n" alone -> no out_valid.
- Backpressure: hold out_ready=0 for 10 cycles after "7," -> out_valid and out_value=7 stable, in_ready=0 throughout, characters driven meanwhile not consumed; release -> handshake completes, next char accepted.
- Assert reset_n=0 after "-9" (no terminator), release, send "5\n" -> out_value=+5, out_err=0. Repeat with reset during out_valid=1 -> out_valid=0 immediately (async).
